// File: rtl/mips_multicycle_ctrl_if.sv
// Memory bus between the multi-cycle control unit and the memory/IR/MDR path.
// The controller owns the request and strobes; memory answers with mem_ack.
interface mips_multicycle_ctrl_if;
    logic mem_req;
    logic mem_ack;
    logic MemRead;
    logic MemWrite;
    logic IorD;

    modport master (
        output mem_req,
        output MemRead,
        output MemWrite,
        output IorD,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  MemRead,
        input  MemWrite,
        input  IorD,
        output mem_ack
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM. Steps each instruction through one-hot stage
// codes, drives the datapath strobes, runs the memory request/ack handshake
// with a bounded wait, and counts retired instructions.
module mips_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [5:0]                opcode,
    input  logic                      zero,
    mips_multicycle_ctrl_if.master    mem,
    output logic [5:0]                state,
    output logic [1:0]                ALUop,
    output logic                      IRWrite,
    output logic                      RegWrite,
    output logic                      RegDst,
    output logic                      MemtoReg,
    output logic                      ALUSrc,
    output logic                      PCWrite,
    output logic                      retire,
    output logic [CNT_W-1:0]          instr_count,
    output logic                      halted,
    output logic                      illegal,
    output logic                      bus_err
);

    // The state register holds the one-hot code consumed downstream directly.
    typedef enum logic [5:0] {
        S_FETCH     = 6'b000001,
        S_DECODE    = 6'b000010,
        S_REGREAD   = 6'b000100,
        S_EXECUTE   = 6'b001000,
        S_MEMORY    = 6'b010000,
        S_WRITEBACK = 6'b100000,
        S_HALT      = 6'b000000
    } state_e;

    typedef enum logic [2:0] {
        CLS_R, CLS_LW, CLS_SW, CLS_BEQ, CLS_HLT, CLS_ILL
    } cls_e;

    // Last wait cycle: a request still unacknowledged here raises a bus error.
    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_e           state_q, state_d;
    cls_e             cls_q, cls_d;
    cls_e             op_cls;
    logic [7:0]       wait_q, wait_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             halted_q, halted_d;
    logic             illegal_q, illegal_d;
    logic             bus_err_q, bus_err_d;

    logic       mem_req_c, mem_read_c, mem_write_c, iord_c;
    logic       irwrite_c, regwrite_c, regdst_c, memtoreg_c, alusrc_c;
    logic       pcwrite_c, retire_c;
    logic [1:0] aluop_c;

    function automatic logic [1:0] aluop_of(input cls_e c);
        case (c)
            CLS_R:   return 2'b10;
            CLS_BEQ: return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // Opcode classification, only consumed while in DECODE.
    always_comb begin
        case (opcode)
            6'b000000: op_cls = CLS_R;
            6'b100011: op_cls = CLS_LW;
            6'b101011: op_cls = CLS_SW;
            6'b000100: op_cls = CLS_BEQ;
            6'b111111: op_cls = CLS_HLT;
            default:   op_cls = CLS_ILL;
        endcase
    end

    // Next-state, strobes, wait counter, retire counter and sticky flags.
    always_comb begin
        state_d     = state_q;
        cls_d       = cls_q;
        halted_d    = halted_q;
        illegal_d   = illegal_q;
        bus_err_d   = bus_err_q;
        mem_req_c   = 1'b0;
        mem_read_c  = 1'b0;
        mem_write_c = 1'b0;
        iord_c      = 1'b0;
        irwrite_c   = 1'b0;
        regwrite_c  = 1'b0;
        regdst_c    = 1'b0;
        memtoreg_c  = 1'b0;
        alusrc_c    = 1'b0;
        pcwrite_c   = 1'b0;
        retire_c    = 1'b0;
        aluop_c     = 2'b00;

        unique case (state_q)
            S_FETCH: begin
                mem_req_c  = 1'b1;
                mem_read_c = 1'b1;
                if (mem.mem_ack) begin
                    irwrite_c = 1'b1;
                    pcwrite_c = 1'b1;
                    state_d   = S_DECODE;
                end
            end
            S_DECODE: begin
                cls_d = op_cls;
                if (op_cls == CLS_HLT) begin
                    state_d = S_HALT;
                end else if (op_cls == CLS_ILL) begin
                    state_d   = S_HALT;
                    illegal_d = 1'b1;
                end else begin
                    state_d = S_REGREAD;
                end
            end
            S_REGREAD: begin
                aluop_c = aluop_of(cls_q);
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                aluop_c  = aluop_of(cls_q);
                alusrc_c = (cls_q == CLS_LW) || (cls_q == CLS_SW);
                if (cls_q == CLS_BEQ) begin
                    pcwrite_c = zero;
                    retire_c  = 1'b1;
                    state_d   = S_FETCH;
                end else if (cls_q == CLS_R) begin
                    state_d = S_WRITEBACK;
                end else begin
                    state_d = S_MEMORY;
                end
            end
            S_MEMORY: begin
                mem_req_c   = 1'b1;
                iord_c      = 1'b1;
                mem_read_c  = (cls_q == CLS_LW);
                mem_write_c = (cls_q == CLS_SW);
                if (mem.mem_ack) begin
                    if (cls_q == CLS_LW) begin
                        state_d = S_WRITEBACK;
                    end else begin
                        retire_c = 1'b1;
                        state_d  = S_FETCH;
                    end
                end
            end
            S_WRITEBACK: begin
                regwrite_c = 1'b1;
                regdst_c   = (cls_q == CLS_R);
                memtoreg_c = (cls_q == CLS_LW);
                retire_c   = 1'b1;
                state_d    = S_FETCH;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase

        // An ack on the final wait cycle still completes the transfer.
        if (mem_req_c && !mem.mem_ack && (wait_q == WAIT_LAST)) begin
            state_d   = S_HALT;
            bus_err_d = 1'b1;
        end

        if (state_d == S_HALT) begin
            halted_d = 1'b1;
        end

        wait_d = (mem_req_c && !mem.mem_ack && (state_d == state_q)) ? wait_q + 8'd1 : 8'd0;
        cnt_d  = cnt_q + {{(CNT_W-1){1'b0}}, retire_c};
    end

    // Control state register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            cls_q     <= CLS_R;
            wait_q    <= 8'd0;
            cnt_q     <= '0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cls_q     <= cls_d;
            wait_q    <= wait_d;
            cnt_q     <= cnt_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Strobes are forced low while reset is held so the datapath stays idle.
    always_comb begin
        mem.mem_req  = mem_req_c   & rst_n;
        mem.MemRead  = mem_read_c  & rst_n;
        mem.MemWrite = mem_write_c & rst_n;
        mem.IorD     = iord_c      & rst_n;
        IRWrite      = irwrite_c   & rst_n;
        RegWrite     = regwrite_c  & rst_n;
        RegDst       = regdst_c    & rst_n;
        MemtoReg     = memtoreg_c  & rst_n;
        ALUSrc       = alusrc_c    & rst_n;
        PCWrite      = pcwrite_c   & rst_n;
        retire       = retire_c    & rst_n;
        ALUop        = aluop_c     & {2{rst_n}};
    end

    assign state       = state_q;
    assign instr_count = cnt_q;
    assign halted      = halted_q;
    assign illegal     = illegal_q;
    assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for the multi-cycle MIPS control unit.
module tb_mips_multicycle_ctrl;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [5:0]       opcode;
    logic             zero;
    logic [5:0]       state;
    logic [1:0]       ALUop;
    logic             IRWrite, RegWrite, RegDst, MemtoReg, ALUSrc, PCWrite, retire;
    logic [CNT_W-1:0] instr_count;
    logic             halted, illegal, bus_err;

    int n_chk  = 0;
    int n_fail = 0;

    mips_multicycle_ctrl_if bus ();

    mips_multicycle_ctrl #(.MEM_TIMEOUT(15), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .zero        (zero),
        .mem         (bus.master),
        .state       (state),
        .ALUop       (ALUop),
        .IRWrite     (IRWrite),
        .RegWrite    (RegWrite),
        .RegDst      (RegDst),
        .MemtoReg    (MemtoReg),
        .ALUSrc      (ALUSrc),
        .PCWrite     (PCWrite),
        .retire      (retire),
        .instr_count (instr_count),
        .halted      (halted),
        .illegal     (illegal),
        .bus_err     (bus_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    // Drive ack for the current cycle, sample on the falling edge, check state.
    task automatic cyc(input logic ack, input logic [5:0] st, input string tag);
        bus.mem_ack = ack;
        @(negedge clk);
        check(tag, {26'd0, state}, {26'd0, st});
    endtask

    function automatic logic [10:0] strobes();
        return {bus.mem_req, bus.MemRead, bus.MemWrite, bus.IorD, IRWrite,
                RegWrite, RegDst, MemtoReg, ALUSrc, PCWrite, retire};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_state", {26'd0, state}, 32'h01);
        check("rst_strobes", {21'd0, strobes()}, 32'h0);
        check("rst_count", {24'd0, instr_count}, 32'h0);
        check("rst_flags", {29'd0, halted, illegal, bus_err}, 32'h0);
        nxt();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n       = 1'b0;
        opcode      = 6'h00;
        zero        = 1'b0;
        bus.mem_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("init_state", {26'd0, state}, 32'h01);
        check("init_strobes", {21'd0, strobes()}, 32'h0);
        check("init_aluop", {30'd0, ALUop}, 32'h0);
        check("init_count", {24'd0, instr_count}, 32'h0);
        check("init_flags", {29'd0, halted, illegal, bus_err}, 32'h0);
        nxt();
        rst_n = 1'b1;

        // R-type with ack tied high
        opcode = 6'h00;
        cyc(1'b1, 6'h01, "r_fetch");
        check("r_fetch_strb", {27'd0, bus.mem_req, bus.MemRead, bus.IorD, IRWrite, PCWrite}, 32'b11011);
        nxt();
        cyc(1'b1, 6'h02, "r_dec");
        check("r_dec_strb", {21'd0, strobes()}, 32'h0);
        nxt();
        cyc(1'b1, 6'h04, "r_rr");
        check("r_rr_aluop", {30'd0, ALUop}, 32'b10);
        nxt();
        cyc(1'b1, 6'h08, "r_ex");
        check("r_ex_aluop", {30'd0, ALUop}, 32'b10);
        check("r_ex_alusrc", {31'd0, ALUSrc}, 32'd0);
        nxt();
        cyc(1'b1, 6'h20, "r_wb");
        check("r_wb_strb", {28'd0, RegWrite, RegDst, MemtoReg, retire}, 32'b1101);
        check("r_wb_count", {24'd0, instr_count}, 32'd0);
        nxt();

        // LW with the data ack delayed three cycles
        opcode = 6'h23;
        cyc(1'b1, 6'h01, "lw_fetch");
        check("lw_fetch_count", {24'd0, instr_count}, 32'd1);
        nxt();
        cyc(1'b1, 6'h02, "lw_dec");
        nxt();
        cyc(1'b1, 6'h04, "lw_rr");
        check("lw_rr_aluop", {30'd0, ALUop}, 32'b00);
        nxt();
        cyc(1'b1, 6'h08, "lw_ex");
        check("lw_ex_alusrc", {31'd0, ALUSrc}, 32'd1);
        nxt();
        for (int i = 0; i < 4; i++) begin
            cyc(i == 3, 6'h10, "lw_mem");
            check("lw_mem_strb", {28'd0, bus.mem_req, bus.MemRead, bus.MemWrite, bus.IorD}, 32'b1101);
            check("lw_mem_retire", {31'd0, retire}, 32'd0);
            nxt();
        end
        cyc(1'b1, 6'h20, "lw_wb");
        check("lw_wb_strb", {28'd0, RegWrite, RegDst, MemtoReg, retire}, 32'b1011);
        nxt();

        // BEQ taken then not taken
        opcode = 6'h04;
        for (int z = 1; z >= 0; z--) begin
            zero = z[0];
            cyc(1'b1, 6'h01, "beq_fetch");
            nxt();
            cyc(1'b1, 6'h02, "beq_dec");
            nxt();
            cyc(1'b1, 6'h04, "beq_rr");
            check("beq_rr_aluop", {30'd0, ALUop}, 32'b01);
            nxt();
            cyc(1'b1, 6'h08, "beq_ex");
            check("beq_ex_aluop", {30'd0, ALUop}, 32'b01);
            check("beq_ex_pcwrite", {31'd0, PCWrite}, {31'd0, z[0]});
            check("beq_ex_retire", {31'd0, retire}, 32'd1);
            nxt();
        end
        cyc(1'b1, 6'h01, "beq_done");
        check("beq_count", {24'd0, instr_count}, 32'd4);
        nxt();

        // HLT opcode
        do_reset();
        opcode = 6'h3F;
        cyc(1'b1, 6'h01, "hlt_fetch");
        nxt();
        cyc(1'b1, 6'h02, "hlt_dec");
        check("hlt_dec_halted", {31'd0, halted}, 32'd0);
        nxt();
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 6'h00, "hlt_state");
            check("hlt_flags", {29'd0, halted, illegal, bus_err}, 32'b100);
            check("hlt_strobes", {21'd0, strobes()}, 32'h0);
            check("hlt_count", {24'd0, instr_count}, 32'd0);
            nxt();
        end

        // Illegal opcode
        do_reset();
        opcode = 6'h2A;
        cyc(1'b1, 6'h01, "ill_fetch");
        nxt();
        cyc(1'b1, 6'h02, "ill_dec");
        nxt();
        cyc(1'b1, 6'h00, "ill_state");
        check("ill_flags", {29'd0, halted, illegal, bus_err}, 32'b110);
        check("ill_count", {24'd0, instr_count}, 32'd0);
        nxt();

        // Fetch timeout: no ack for 15 cycles
        do_reset();
        opcode = 6'h00;
        for (int k = 1; k <= 15; k++) begin
            cyc(1'b0, 6'h01, "to_wait");
            check("to_wait_req", {31'd0, bus.mem_req}, 32'd1);
            check("to_wait_err", {31'd0, bus_err}, 32'd0);
            nxt();
        end
        cyc(1'b0, 6'h00, "to_halt");
        check("to_halt_req", {31'd0, bus.mem_req}, 32'd0);
        check("to_halt_flags", {29'd0, halted, illegal, bus_err}, 32'b101);
        nxt();

        // Ack on the timeout cycle wins
        do_reset();
        for (int k = 1; k <= 15; k++) begin
            cyc(k == 15, 6'h01, "to15_wait");
            nxt();
        end
        cyc(1'b1, 6'h02, "to15_dec");
        check("to15_err", {31'd0, bus_err}, 32'd0);
        nxt();

        // Counter wrap via SW instructions
        do_reset();
        opcode      = 6'h2B;
        bus.mem_ack = 1'b1;
        repeat (255 * 5) nxt();
        @(negedge clk);
        check("wrap_state", {26'd0, state}, 32'h01);
        check("wrap_allones", {24'd0, instr_count}, 32'hFF);
        repeat (4) nxt();
        cyc(1'b1, 6'h10, "sw_mem");
        check("sw_mem_strb", {28'd0, bus.MemRead, bus.MemWrite, bus.IorD, retire}, 32'b0111);
        nxt();
        cyc(1'b1, 6'h01, "wrap_fetch");
        check("wrap_zero", {24'd0, instr_count}, 32'h00);
        repeat (5) nxt();
        repeat (4) nxt();
        bus.mem_ack = 1'b0;
        @(negedge clk);
        check("abort_mem_state", {26'd0, state}, 32'h10);
        check("abort_pre_count", {24'd0, instr_count}, 32'd1);
        nxt();
        rst_n = 1'b0;
        #1;
        check("abort_state", {26'd0, state}, 32'h01);
        check("abort_strobes", {21'd0, strobes()}, 32'h0);
        check("abort_count", {24'd0, instr_count}, 32'd0);
        nxt();
        rst_n = 1'b1;
        #1;
        check("abort_refetch_req", {31'd0, bus.mem_req}, 32'd1);
        nxt();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
